// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kbd_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } kbd_rx_state_t;

    localparam logic KBD_START_BIT = 1'b0;
    localparam logic KBD_STOP_BIT  = 1'b1;
    localparam int   KBD_DATA_BITS = 8;

    // True when the data byte plus its parity bit hold an odd number of ones.
    function automatic logic kbd_parity_ok(input logic [KBD_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/kbd_scan_rx_if.sv
// Drain-side bundle between the scan-code receiver and the keyboard peripheral.
// Latency: n/a (wires only).
// Backpressure: kbd_ready from the peripheral gates every kbd_write strobe.
interface kbd_scan_rx_if #(
    parameter int FIFO_DEPTH = 4
);
    import kbd_pkg::*;

    logic                       kbd_ready;
    logic                       kbd_write;
    logic [KBD_DATA_BITS-1:0]   kbd_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        input  kbd_ready,
        output kbd_write,
        output kbd_data,
        output fifo_count
    );

    modport slave (
        output kbd_ready,
        input  kbd_write,
        input  kbd_data,
        input  fifo_count
    );

endinterface

// File: rtl/kbd_fifo.sv
// Small synchronous FIFO buffering received scan codes; head visible combinationally on dout.
// Latency: push visible in count/dout the cycle after; pop advances the head the cycle after.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module kbd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_scan_rx.sv
// PS/2 keyboard receiver: synchronize, deserialize 11-bit frames, buffer and drain scan codes.
// Latency: pin to edge detect 3 cycles; stop edge to FIFO 1 cycle; FIFO to kbd_write 1 cycle.
// Backpressure: kbd_ready low holds codes in the FIFO; a full FIFO drops new codes and flags overflow.
module kbd_scan_rx
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    input  logic          clear_err,
    output logic          parity_err,
    output logic          frame_err,
    output logic          overflow,
    kbd_scan_rx_if.master bus
);
    localparam int BCW = $clog2(KBD_DATA_BITS);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    // Synchronizer and edge-detect state.
    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall_q, bit_q;

    // Frame-tracking state.
    kbd_rx_state_t            state_q, state_n;
    logic [BCW-1:0]           bitcnt_q, bitcnt_n;
    logic [KBD_DATA_BITS-1:0] shreg_q, shreg_n;
    logic                     par_q, par_n;
    logic [TW-1:0]            tmo_q, tmo_n;

    logic push_req, perr_set, ferr_set, ovf_set;

    // FIFO / drain.
    logic                     pop;
    logic                     fifo_full, fifo_empty;
    logic [KBD_DATA_BITS-1:0] fifo_dout;
    logic [CW-1:0]            fifo_cnt;
    logic                     write_q;
    logic [KBD_DATA_BITS-1:0] data_q;

    // Two-flop synchronizers, then a registered falling-edge flag with the data bit aligned to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            fall_q   <= 1'b0;
            bit_q    <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
            fall_q   <= clk_prev & ~clk_s2;
            bit_q    <= dat_s2;
        end
    end

    // Frame state register and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_n;
            bitcnt_q <= bitcnt_n;
            shreg_q  <= shreg_n;
            par_q    <= par_n;
            tmo_q    <= tmo_n;
        end
    end

    // Next-state: sample bits only on detected falling edges; a stalled partial frame times out.
    always_comb begin
        state_n  = state_q;
        bitcnt_n = bitcnt_q;
        shreg_n  = shreg_q;
        par_n    = par_q;
        tmo_n    = tmo_q;
        push_req = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;

        if (state_q == IDLE || fall_q) begin
            tmo_n = '0;
        end else begin
            tmo_n = tmo_q + 1'b1;
        end

        if (state_q != IDLE && !fall_q && tmo_q == TW'(TIMEOUT_CYCLES)) begin
            state_n  = IDLE;
            shreg_n  = '0;
            tmo_n    = '0;
            ferr_set = 1'b1;
        end else if (fall_q) begin
            case (state_q)
                IDLE: begin
                    // A high data bit here is a glitch, not a start bit.
                    if (bit_q == KBD_START_BIT) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n  = {bit_q, shreg_q[KBD_DATA_BITS-1:1]};
                    bitcnt_n = bitcnt_q + 1'b1;
                    if (bitcnt_q == BCW'(KBD_DATA_BITS - 1)) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    par_n   = bit_q;
                    state_n = STOP;
                end
                STOP: begin
                    if (bit_q == KBD_STOP_BIT) begin
                        if (kbd_parity_ok(shreg_q, par_q)) begin
                            push_req = 1'b1;
                        end else begin
                            perr_set = 1'b1;
                        end
                    end else begin
                        ferr_set = 1'b1;
                    end
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign pop     = ~fifo_empty & bus.kbd_ready;
    assign ovf_set = push_req & fifo_full & ~pop;

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KBD_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (shreg_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // Drain register: one strobe per popped code; data holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            data_q  <= '0;
        end else begin
            write_q <= pop;
            if (pop) begin
                data_q <= fifo_dout;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            parity_err <= perr_set | (parity_err & ~clear_err);
            frame_err  <= ferr_set | (frame_err  & ~clear_err);
            overflow   <= ovf_set  | (overflow   & ~clear_err);
        end
    end

    assign bus.kbd_write  = write_q;
    assign bus.kbd_data   = data_q;
    assign bus.fifo_count = fifo_cnt;

endmodule

// File: tb/tb_kbd_scan_rx.sv
// Directed bench for kbd_scan_rx: PS/2 frames driven bit by bit, strobes captured by a monitor.
// Latency: n/a.
// Backpressure: kbd_ready toggled by the stimulus to exercise buffering and overflow.
module tb_kbd_scan_rx;
    localparam int DEPTH = 4;
    localparam int TMO   = 200;
    localparam int HALF  = 8;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic ps2_clk   = 1'b1;
    logic ps2_data  = 1'b1;
    logic clear_err = 1'b0;
    logic parity_err, frame_err, overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] wr_data [$];
    int         wr_cyc  [$];

    kbd_scan_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    kbd_scan_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .clear_err  (clear_err),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter used to verify back-to-back strobes.
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst && bus.kbd_write) begin
            wr_data.push_back(bus.kbd_data);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] get_wr(input int i);
        if (i < wr_data.size()) return {24'h0, wr_data[i]};
        return 32'hDEAD;
    endfunction

    function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stp);
        return {stp, par, d, 1'b0};
    endfunction

    function automatic logic good_par(input logic [7:0] d);
        return ~^d;
    endfunction

    // Drive the first nbits of a frame, LSB (start bit) first.
    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            idle(HALF);
            ps2_clk = 1'b0;
            idle(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic clear_wr();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_write"},  {31'h0, bus.kbd_write}, 32'h0);
        check({pfx, "_data"},   {24'h0, bus.kbd_data}, 32'h0);
        check({pfx, "_count"},  {29'h0, bus.fifo_count}, 32'h0);
        check({pfx, "_perr"},   {31'h0, parity_err}, 32'h0);
        check({pfx, "_ferr"},   {31'h0, frame_err}, 32'h0);
        check({pfx, "_ovf"},    {31'h0, overflow}, 32'h0);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        idle(1);
    endtask

    initial begin
        bus.kbd_ready = 1'b0;
        rst = 1'b1;
        idle(3);
        check_reset_vals("reset");
        rst = 1'b0;
        idle(2);

        // Valid frame 0x1C drains as a single strobe.
        clear_wr();
        bus.kbd_ready = 1'b1;
        send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
        idle(20);
        check("t1_nstrobe", wr_data.size(), 1);
        check("t1_data", get_wr(0), 32'h1C);
        check("t1_hold_data", {24'h0, bus.kbd_data}, 32'h1C);
        check("t1_count", {29'h0, bus.fifo_count}, 0);
        check("t1_perr", {31'h0, parity_err}, 0);
        check("t1_ferr", {31'h0, frame_err}, 0);
        check("t1_ovf", {31'h0, overflow}, 0);

        // 0xF0 with even total parity is rejected.
        clear_wr();
        send_bits(mk(8'hF0, 1'b0, 1'b1), 11);
        idle(20);
        check("t2_perr", {31'h0, parity_err}, 1);
        check("t2_ferr", {31'h0, frame_err}, 0);
        check("t2_nstrobe", wr_data.size(), 0);
        check("t2_count", {29'h0, bus.fifo_count}, 0);
        pulse_clear();
        check("t2_perr_clr", {31'h0, parity_err}, 0);

        // Five codes into a four-entry FIFO with the drain stalled.
        clear_wr();
        bus.kbd_ready = 1'b0;
        for (int d = 1; d <= 5; d++) begin
            send_bits(mk(8'(d), good_par(8'(d)), 1'b1), 11);
        end
        idle(20);
        check("t3_count_full", {29'h0, bus.fifo_count}, 4);
        check("t3_ovf", {31'h0, overflow}, 1);
        check("t3_nstrobe_stall", wr_data.size(), 0);
        bus.kbd_ready = 1'b1;
        idle(10);
        check("t3_nstrobe", wr_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_data%0d", i), get_wr(i), 32'(i + 1));
        end
        check("t3_b2b", (wr_cyc.size() == 4) ? 32'(wr_cyc[3] - wr_cyc[0]) : 32'hDEAD, 3);
        check("t3_count_empty", {29'h0, bus.fifo_count}, 0);
        pulse_clear();
        check("t3_ovf_clr", {31'h0, overflow}, 0);

        // Start plus three data bits then silence: timeout abort.
        clear_wr();
        send_bits(mk(8'h07, 1'b0, 1'b1), 4);
        idle(TMO + 5 + 10);
        check("t4_ferr", {31'h0, frame_err}, 1);
        check("t4_count", {29'h0, bus.fifo_count}, 0);
        check("t4_nstrobe", wr_data.size(), 0);
        pulse_clear();
        send_bits(mk(8'h2A, 1'b0, 1'b1), 11);
        idle(20);
        check("t4_next_nstrobe", wr_data.size(), 1);
        check("t4_next_data", get_wr(0), 32'h2A);
        check("t4_next_ferr", {31'h0, frame_err}, 0);
        check("t4_next_perr", {31'h0, parity_err}, 0);

        // Bad stop bit.
        clear_wr();
        send_bits(mk(8'h5A, 1'b1, 1'b0), 11);
        idle(20);
        check("t5_ferr", {31'h0, frame_err}, 1);
        check("t5_perr", {31'h0, parity_err}, 0);
        check("t5_count", {29'h0, bus.fifo_count}, 0);
        check("t5_nstrobe", wr_data.size(), 0);

        // Reset mid-frame with two codes buffered and frame_err still set.
        clear_wr();
        bus.kbd_ready = 1'b0;
        send_bits(mk(8'h11, 1'b1, 1'b1), 11);
        send_bits(mk(8'h22, 1'b1, 1'b1), 11);
        idle(20);
        check("t6_count_pre", {29'h0, bus.fifo_count}, 2);
        send_bits(mk(8'h33, 1'b1, 1'b1), 5);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_reset_vals("t6_rst");
        bus.kbd_ready = 1'b1;
        idle(40);
        check("t6_nstrobe", wr_data.size(), 0);
        check("t6_count_post", {29'h0, bus.fifo_count}, 0);
        check("t6_ferr_post", {31'h0, frame_err}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kbd_scan_rx.md
# kbd_scan_rx

PS/2-style serial keyboard receiver feeding the keyboard peripheral register in the shared-RAM SoC. It synchronizes the external keyboard clock and data lines, deserializes 11-bit frames (start, 8 data LSB-first, odd parity, stop), and buffers valid scan codes in a small FIFO. Buffered codes are drained as one-cycle write strobes plus a data byte, wired directly to the keyboard peripheral's `write`/`data_in`.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: scan-code buffer entries; must be a power of two, 2 or more.
- `TIMEOUT_CYCLES`, 2000: `clk` cycles without a keyboard-clock falling edge before a partial frame is aborted.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ps2_clk`  in  1  asynchronous keyboard clock line.
- `ps2_data`  in  1  asynchronous keyboard data line.
- `kbd_ready`  in  1  downstream may accept a byte this cycle.
- `kbd_write`  out  1  one-cycle write strobe to the keyboard peripheral.
- `kbd_data`  out  8  scan code; valid while `kbd_write` is high.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current number of buffered codes.
- `clear_err`  in  1  clears the sticky error flags.
- `parity_err`  out  1  sticky; a frame failed the odd-parity check.
- `frame_err`  out  1  sticky; bad stop bit or timeout abort.
- `overflow`  out  1  sticky; a valid frame was dropped because the FIFO was full.

## Operation
- Two-flop synchronizer on `ps2_clk` and `ps2_data`, reset to 1. An edge register flags a falling edge when the previous synchronized clock was 1 and the current one is 0.
- FSM states are IDLE, DATA, PARITY and STOP. All bit sampling happens only on detected falling edges.
  - IDLE: if the edge arrives with data 0, go to DATA and clear `bitcnt`. If data is 1, stay in IDLE (glitch ignored, no error).
  - DATA: shift the bit into `shreg[7]`, shifting right. After the 8th bit go to PARITY.
  - PARITY: latch the parity bit and go to STOP.
  - STOP: if stop is 1 and the XOR of data and parity is 1, push `shreg` to the FIFO. A bad parity with a good stop sets `parity_err`. A stop bit of 0 sets `frame_err` and nothing is pushed. Always return to IDLE.
- Timeout counter:
  - Cleared on every falling edge and whenever the FSM is in IDLE.
  - If it reaches `TIMEOUT_CYCLES` outside IDLE, the FSM goes to IDLE, sets `frame_err`, and discards the partial byte.
- FIFO push when full: the byte is dropped and `overflow` is set. Exception: a pop in the same cycle frees a slot, so the push is accepted and the count is unchanged.
- Drain:
  - When the FIFO is non-empty and `kbd_ready` is high, pop the head and register it into `kbd_data`, with `kbd_write` set for exactly the next cycle.
  - Back-to-back strobes occur while `kbd_ready` stays high and data remains.
- `kbd_data` holds its last value when `kbd_write` is low.
- Sticky flags: `clear_err` clears all three. If a new error and `clear_err` occur in the same cycle, the set wins.

## Timing
- Reset values:
  - `kbd_write`=0, `kbd_data`=0x00, `fifo_count`=0.
  - `parity_err`, `frame_err`, `overflow` all 0.
  - FSM in IDLE, synchronizers at 1, timeout counter 0.
- Reset mid-frame discards the partial frame and all FIFO contents.
- Pin-to-edge-detect latency: 3 `clk` cycles.
- Stop-bit edge detected in cycle E:
  - FIFO write and `fifo_count` increment are visible in E+1.
  - `kbd_write` is high in E+2 if `kbd_ready` was high in E+1.
- Pop path: `kbd_ready` sampled in cycle C gives `kbd_write`=1 in C+1, and `fifo_count` is decremented in C+1.
- `fifo_count` saturates at `FIFO_DEPTH` and never wraps. Read and write pointers wrap modulo `FIFO_DEPTH`.

## Structure
- Package `kbd_pkg`:
  - FSM state enum `kbd_rx_state_t`.
  - Constants `KBD_START_BIT`=0, `KBD_STOP_BIT`=1, `KBD_DATA_BITS`=8.
- Sub-module `kbd_fifo`: a synchronous FIFO with parameter `DEPTH`, ports `push`/`pop`/`din`/`dout`/`full`/`empty`/`count`, and simultaneous push and pop allowed when full.
- Top-level `kbd_scan_rx` contains the synchronizers, edge detector, FSM, timeout counter, error flags and drain register.

## Test plan
- Frame 0x1C with parity 0 and stop 1, `kbd_ready`=1: exactly one `kbd_write` pulse with `kbd_data`=0x1C; no error flags set.
- Frame 0xF0 sent with parity 0 (wrong): nothing pushed, `parity_err`=1. Then pulse `clear_err`: `parity_err`=0.
- With `kbd_ready`=0, send 5 valid frames 0x01..0x05 at `FIFO_DEPTH`=4: `fifo_count`=4 and `overflow`=1. Then raise `kbd_ready`: 4 consecutive strobes carrying 0x01..0x04.
- Send start plus 3 data bits, then stop toggling for `TIMEOUT_CYCLES`+5 cycles: `frame_err`=1, FSM back in IDLE, nothing pushed. A following frame 0x2A is received correctly.
- Frame 0x5A with stop bit 0: `frame_err`=1, `fifo_count` stays 0.
- Assert `rst` for one cycle after the 4th data bit of a frame with 2 entries already buffered: all outputs return to their reset values and no strobe follows.
